inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end.
//
// Issues word addresses to a registered instruction ROM. Returned
// instructions go into a 2-entry output FIFO as {pc, inst} pairs. Fetch
// stalls while the FIFO plus the in-flight response would fill it. A redirect
// flushes the FIFO and the in-flight response, then restarts fetch at the
// target address.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   imem_addr      word address presented to the ROM this cycle
//   imem_inst      ROM data for the address presented in the previous cycle
//   redirect       branch/jump restart request (one-cycle pulse)
//   redirect_addr  restart target word address, valid with redirect
//   out_valid      head entry holds a fetched instruction
//   out_ready      consumer takes the head entry this cycle
//   out_inst       head instruction
//   out_pc         head byte address {word_addr, 2'b00}
module inst_fetch #(
  parameter logic [29:0] RESET_PC = 30'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect,
  input  logic [29:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [29:0] rsp_pc_q, rsp_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [29:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [31:0] e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;

  logic        pop;
  logic [2:0]  occ;
  logic [1:0]  cnt_after_pop;
  logic        issue;

  // Entry 0 is always the head. A pop shifts entry 1 down, so the outputs
  // come straight from registers.
  assign out_valid = (cnt_q != 2'd0);
  assign out_pc    = {e0_pc_q, 2'b00};
  assign out_inst  = e0_inst_q;

  assign imem_addr = rst      ? RESET_PC      :
                     redirect ? redirect_addr : fetch_pc_q;

  always_comb begin
    pop           = out_valid && out_ready;
    occ           = {1'b0, cnt_q} + {2'b00, rsp_valid_q} - {2'b00, pop};
    cnt_after_pop = cnt_q - {1'b0, pop};
    issue         = !redirect && (occ < 3'd2);

    fetch_pc_d  = fetch_pc_q;
    rsp_valid_d = 1'b0;
    rsp_pc_d    = rsp_pc_q;
    cnt_d       = cnt_q;
    e0_pc_d     = e0_pc_q;
    e0_inst_d   = e0_inst_q;
    e1_pc_d     = e1_pc_q;
    e1_inst_d   = e1_inst_q;

    if (redirect) begin
      // Flush wins over pop and over the in-flight write.
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_pc_d    = redirect_addr;
      fetch_pc_d  = redirect_addr + 30'd1;
    end else begin
      if (pop) begin
        e0_pc_d   = e1_pc_q;
        e0_inst_d = e1_inst_q;
      end
      if (rsp_valid_q) begin
        if (cnt_after_pop == 2'd0) begin
          e0_pc_d   = rsp_pc_q;
          e0_inst_d = imem_inst;
        end else begin
          e1_pc_d   = rsp_pc_q;
          e1_inst_d = imem_inst;
        end
      end
      cnt_d = occ[1:0];
      if (issue) begin
        rsp_valid_d = 1'b1;
        rsp_pc_d    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + 30'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      cnt_q       <= '0;
      e0_pc_q     <= '0;
      e0_inst_q   <= '0;
      e1_pc_q     <= '0;
      e1_inst_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      cnt_q       <= cnt_d;
      e0_pc_q     <= e0_pc_d;
      e0_inst_q   <= e0_inst_d;
      e1_pc_q     <= e1_pc_d;
      e1_inst_q   <= e1_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch.
//
// Two instances share the same stimulus: one uses the default RESET_PC and
// the other uses RESET_PC = 3FFFFFFF, so the wrap case is exercised.
// Each instance has its own registered ROM that returns {2'b10, addr}.
// A queue-based reference model predicts imem_addr and the output stream.
module tb_inst_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [29:0] redirect_addr = '0;
  logic        out_ready = 1'b0;

  logic [29:0] imem_addr [2];
  logic [31:0] imem_inst [2];
  logic        out_valid [2];
  logic [31:0] out_inst  [2];
  logic [31:0] out_pc    [2];

  inst_fetch u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr[0]),
    .imem_inst     (imem_inst[0]),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid[0]),
    .out_ready     (out_ready),
    .out_inst      (out_inst[0]),
    .out_pc        (out_pc[0])
  );

  inst_fetch #(.RESET_PC(30'h3FFFFFFF)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr[1]),
    .imem_inst     (imem_inst[1]),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid[1]),
    .out_ready     (out_ready),
    .out_inst      (out_inst[1]),
    .out_pc        (out_pc[1])
  );

  // Instruction ROMs: one-cycle registered read.
  always @(posedge clk) begin
    imem_inst[0] <= {2'b10, imem_addr[0]};
    imem_inst[1] <= {2'b10, imem_addr[1]};
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state for each instance.
  logic [29:0] m_rpc [2];
  logic [29:0] m_fpc [2];
  bit          m_infl[2];
  logic [29:0] m_ipc [2];
  logic [29:0] m_q   [2][$];
  bit          m_zero[2];
  bit          m_init = 1'b0;

  // Each call is one clock cycle. Inputs are driven at the falling edge, the
  // outputs are checked 1ns later, and the model advances at the rising edge.
  task automatic cycle(input bit r, input bit rd, input logic [29:0] ra, input bit rdy);
    logic [29:0] eaddr;
    bit          pop;
    @(negedge clk);
    rst = r;
    redirect = rd;
    redirect_addr = ra;
    out_ready = rdy;
    #1;
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        eaddr = r ? m_rpc[k] : (rd ? ra : m_fpc[k]);
        check($sformatf("imem_addr[%0d]", k), 64'(imem_addr[k]), 64'(eaddr));
        check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_q[k].size() != 0));
        if (m_q[k].size() != 0) begin
          check($sformatf("out_pc[%0d]", k), 64'(out_pc[k]), 64'({m_q[k][0], 2'b00}));
          check($sformatf("out_inst[%0d]", k), 64'(out_inst[k]), 64'({2'b10, m_q[k][0]}));
        end else if (m_zero[k]) begin
          check($sformatf("rst_out_pc[%0d]", k), 64'(out_pc[k]), 64'd0);
          check($sformatf("rst_out_inst[%0d]", k), 64'(out_inst[k]), 64'd0);
        end
      end
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_fpc[k] = m_rpc[k];
        m_infl[k] = 1'b0;
        m_q[k].delete();
        m_zero[k] = 1'b1;
      end else if (rd) begin
        m_q[k].delete();
        m_infl[k] = 1'b1;
        m_ipc[k] = ra;
        m_fpc[k] = ra + 30'd1;
      end else begin
        pop = (m_q[k].size() != 0) && rdy;
        if (pop) void'(m_q[k].pop_front());
        if (m_infl[k]) begin
          m_q[k].push_back(m_ipc[k]);
          m_zero[k] = 1'b0;
        end
        // Fetch only when the FIFO will still have room for the new response.
        if (m_q[k].size() < 2) begin
          m_infl[k] = 1'b1;
          m_ipc[k] = m_fpc[k];
          m_fpc[k] = m_fpc[k] + 30'd1;
        end else begin
          m_infl[k] = 1'b0;
        end
      end
    end
    if (r) m_init = 1'b1;
  endtask

  initial begin
    logic [29:0] ra;
    bit          rd;
    m_rpc[0] = 30'h00000000;
    m_rpc[1] = 30'h3FFFFFFF;

    // Reset release followed by free-running fetch.
    repeat (3) cycle(1, 0, '0, 1);
    repeat (6) cycle(0, 0, '0, 1);

    // Consumer stall after reset, then resume.
    repeat (2) cycle(1, 0, '0, 1);
    repeat (5) cycle(0, 0, '0, 0);
    repeat (3) cycle(0, 0, '0, 1);

    // Redirect while the FIFO is full.
    repeat (3) cycle(0, 0, '0, 0);
    cycle(0, 1, 30'h100, 0);
    repeat (4) cycle(0, 0, '0, 1);

    // Redirect issued together with a pop.
    cycle(0, 1, 30'h200, 1);
    repeat (3) cycle(0, 0, '0, 1);

    // Back-to-back redirects, including one to the top of memory.
    cycle(0, 1, 30'h300, 1);
    cycle(0, 1, 30'h3FFFFFFF, 1);
    cycle(0, 1, 30'h10, 0);
    repeat (4) cycle(0, 0, '0, 1);

    // Mid-stream reset while the FIFO is full, with a redirect and a pop in the same cycle.
    repeat (4) cycle(0, 0, '0, 0);
    cycle(1, 1, 30'h55, 1);
    repeat (5) cycle(0, 0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 7) == 0);
      ra = ($urandom_range(0, 3) == 0) ? (30'h3FFFFFFE + 30'($urandom_range(0, 2)))
                                      : 30'($urandom);
      cycle($urandom_range(0, 63) == 0, rd, ra, $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
